// File: rtl/vid_stream_gen.sv
// Test-pattern video stream source: ACT/HBLK/VBLK timing with registered strobes.
// Define VSG_FRM_CNT_EN to build the completed-frame counter on o_frm_cnt.
module vid_stream_gen #(
    parameter int DBUF_DW = 8,
    parameter int IMG_HSZ = 1920,
    parameter int IMG_VSZ = 1080,
    parameter int HBLK_SZ = 280,
    parameter int VBLK_SZ = 45
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_pat_sel,
    input  logic [DBUF_DW-1:0] i_solid,
    output logic [DBUF_DW-1:0] o_data,
    output logic               o_href,
    output logic               o_hstr,
    output logic               o_hend,
    output logic               o_vstr,
    output logic               o_vend,
    output logic               o_busy,
    output logic [15:0]        o_frm_cnt
);

    localparam int LINE_CYC = IMG_HSZ + HBLK_SZ;
    localparam int VBLK_CYC = VBLK_SZ * LINE_CYC;
    localparam int CW = $clog2(VBLK_CYC + IMG_HSZ + 1);
    localparam int VW = $clog2(IMG_VSZ + 1);
    localparam logic [CW-1:0] H_LAST  = CW'(IMG_HSZ - 1);
    localparam logic [CW-1:0] HB_LAST = CW'(HBLK_SZ - 1);
    localparam logic [CW-1:0] VB_LAST = CW'(VBLK_CYC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(IMG_VSZ - 1);

    typedef enum logic [1:0] {IDLE, ACT, HBLK, VBLK} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      hcnt_q, hcnt_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic               stop_q, stop_d;
    logic [1:0]         pat_q, pat_d;
    logic [DBUF_DW-1:0] solid_q, solid_d;
    logic [DBUF_DW-1:0] data_q, data_d;
    logic               href_q, href_d;
    logic               hstr_q, hstr_d;
    logic               hend_q, hend_d;
    logic               vstr_q, vstr_d;
    logic               vend_q, vend_d;
    logic               busy_q, busy_d;
    logic               stop_set;
    logic               frame_go;
    logic [31:0]        h32;
    logic [31:0]        v32;
    logic [DBUF_DW-1:0] pix;

    // Outputs are registered from the next-state position, so the pixel
    // shown in a cycle belongs to the state entered at that cycle's edge.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        frame_go = 1'b0;
        stop_set = stop_q | (i_stop & ((state_q != IDLE) | i_start));
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = ACT;
                    hcnt_d   = '0;
                    vcnt_d   = '0;
                    frame_go = 1'b1;
                end
            end
            ACT: begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d  = '0;
                    state_d = (vcnt_q == V_LAST) ? VBLK : HBLK;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            HBLK: begin
                if (hcnt_q == HB_LAST) begin
                    hcnt_d  = '0;
                    vcnt_d  = vcnt_q + 1'b1;
                    state_d = ACT;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            VBLK: begin
                if (hcnt_q == VB_LAST) begin
                    hcnt_d = '0;
                    vcnt_d = '0;
                    if (stop_set) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = ACT;
                        frame_go = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        stop_d  = (state_d == IDLE) ? 1'b0 : stop_set;
        pat_d   = frame_go ? i_pat_sel : pat_q;
        solid_d = frame_go ? i_solid : solid_q;

        h32 = 32'(hcnt_d);
        v32 = 32'(vcnt_d);
        case (pat_d)
            2'd0:    pix = h32[DBUF_DW-1:0];
            2'd1:    pix = v32[DBUF_DW-1:0];
            2'd2:    pix = solid_d;
            default: pix = {DBUF_DW{h32[3] ^ v32[3]}};
        endcase

        href_d = (state_d == ACT);
        hstr_d = href_d && (hcnt_d == '0);
        hend_d = href_d && (hcnt_d == H_LAST);
        vstr_d = hstr_d && (vcnt_d == '0);
        vend_d = hend_d && (vcnt_d == V_LAST);
        data_d = href_d ? pix : '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            stop_q  <= 1'b0;
            pat_q   <= '0;
            solid_q <= '0;
            data_q  <= '0;
            href_q  <= 1'b0;
            hstr_q  <= 1'b0;
            hend_q  <= 1'b0;
            vstr_q  <= 1'b0;
            vend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            stop_q  <= stop_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            data_q  <= data_d;
            href_q  <= href_d;
            hstr_q  <= hstr_d;
            hend_q  <= hend_d;
            vstr_q  <= vstr_d;
            vend_q  <= vend_d;
            busy_q  <= busy_d;
        end
    end

`ifdef VSG_FRM_CNT_EN
    logic [15:0] frm_cnt_q, frm_cnt_d;

    assign frm_cnt_d = frm_cnt_q + {15'd0, vend_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frm_cnt_q <= '0;
        else     frm_cnt_q <= frm_cnt_d;
    end

    assign o_frm_cnt = frm_cnt_q;
`else
    assign o_frm_cnt = '0;
`endif

    assign o_data = data_q;
    assign o_href = href_q;
    assign o_hstr = hstr_q;
    assign o_hend = hend_q;
    assign o_vstr = vstr_q;
    assign o_vend = vend_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_vid_stream_gen.sv
// Scoreboard bench for vid_stream_gen: two small-geometry instances,
// expected pixels queued by stimulus and popped by a monitor on o_href.
module tb_vid_stream_gen;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       hs;
        logic       he;
        logic       vs;
        logic       ve;
    } exp_t;

`ifdef VSG_FRM_CNT_EN
    localparam int FC = 1;
`else
    localparam int FC = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, stop;
    logic [1:0] pat;
    logic [7:0] solid;
    logic [7:0] a_data;
    logic a_href, a_hstr, a_hend, a_vstr, a_vend, a_busy;
    logic [15:0] a_frm;

    logic b_start, b_stop;
    logic [7:0] b_data;
    logic b_href, b_hstr, b_hend, b_vstr, b_vend, b_busy;
    logic [15:0] b_frm;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q1[$];
    exp_t q2[$];

    vid_stream_gen #(
        .DBUF_DW(8), .IMG_HSZ(4), .IMG_VSZ(3), .HBLK_SZ(2), .VBLK_SZ(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .i_start(start), .i_stop(stop),
        .i_pat_sel(pat), .i_solid(solid), .o_data(a_data),
        .o_href(a_href), .o_hstr(a_hstr), .o_hend(a_hend),
        .o_vstr(a_vstr), .o_vend(a_vend), .o_busy(a_busy),
        .o_frm_cnt(a_frm)
    );

    vid_stream_gen #(
        .DBUF_DW(8), .IMG_HSZ(16), .IMG_VSZ(2), .HBLK_SZ(1), .VBLK_SZ(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .i_start(b_start), .i_stop(b_stop),
        .i_pat_sel(2'd3), .i_solid(8'h00), .o_data(b_data),
        .o_href(b_href), .o_hstr(b_hstr), .o_hend(b_hend),
        .o_vstr(b_vstr), .o_vend(b_vend), .o_busy(b_busy),
        .o_frm_cnt(b_frm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic sample_at(input int n);
        at_cycle(n);
        #1;
    endtask

    // Pixels of one frame; anything after last_cyc is dropped (aborted frame).
    task automatic push_frame(input int t0, input int p, input logic [7:0] sol,
                              input int hsz, input int vsz, input int line_cyc,
                              input int last_cyc, input bit to_b);
        exp_t e;
        for (int v = 0; v < vsz; v++) begin
            for (int h = 0; h < hsz; h++) begin
                e.cyc = t0 + v * line_cyc + h;
                case (p)
                    0: e.d = 8'(h);
                    1: e.d = 8'(v);
                    2: e.d = sol;
                    default: e.d = (((h >> 3) ^ (v >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
                endcase
                e.hs = (h == 0);
                e.he = (h == hsz - 1);
                e.vs = (h == 0) && (v == 0);
                e.ve = (h == hsz - 1) && (v == vsz - 1);
                if (e.cyc <= last_cyc) begin
                    if (to_b) q2.push_back(e);
                    else      q1.push_back(e);
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (a_href) begin
                if (q1.size() == 0) begin
                    chk("a_extra_pixel", 64'(cyc), 64'(-1));
                end else begin
                    e = q1.pop_front();
                    chk("a_pix_cycle", 64'(cyc), 64'(e.cyc));
                    chk("a_pix", {a_data, a_hstr, a_hend, a_vstr, a_vend},
                        {e.d, e.hs, e.he, e.vs, e.ve});
                end
            end else begin
                chk("a_blank", {a_data, a_hstr, a_hend, a_vstr, a_vend}, 64'd0);
            end
            if (b_href) begin
                if (q2.size() == 0) begin
                    chk("b_extra_pixel", 64'(cyc), 64'(-1));
                end else begin
                    e = q2.pop_front();
                    chk("b_pix_cycle", 64'(cyc), 64'(e.cyc));
                    chk("b_pix", {b_data, b_hstr, b_hend, b_vstr, b_vend},
                        {e.d, e.hs, e.he, e.vs, e.ve});
                end
            end else begin
                chk("b_blank", {b_data, b_hstr, b_hend, b_vstr, b_vend}, 64'd0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        pat = 2'd0;
        solid = 8'h00;
        b_start = 1'b0;
        b_stop = 1'b0;

        sample_at(1);
        chk("a_reset_outs", {a_data, a_href, a_hstr, a_hend, a_vstr, a_vend,
            a_busy, a_frm}, 64'd0);
        chk("b_reset_outs", {b_data, b_href, b_busy, b_frm}, 64'd0);
        at_cycle(2);
        rst = 1'b0;
        sample_at(5);
        chk("idle_after_rst", 64'(a_busy), 64'd0);

        // Continuous run: frame 1 pattern 0, frame 2 pattern 1 selected mid-frame 1.
        push_frame(11, 0, 8'h00, 4, 3, 6, 1000, 1'b0);
        push_frame(33, 1, 8'h00, 4, 3, 6, 1000, 1'b0);
        sample_at(10);
        chk("busy_pre_start", 64'(a_busy), 64'd0);
        start = 1'b1;
        sample_at(11);
        start = 1'b0;
        chk("busy_first_px", 64'(a_busy), 64'd1);
        at_cycle(20);
        pat = 2'd1;
        sample_at(26);
        chk("frm_before_vend", 64'(a_frm), 64'd0);
        sample_at(27);
        chk("frm_after_f1", 64'(a_frm), 64'(FC * 1));
        at_cycle(35);
        pat = 2'd2;
        start = 1'b1;
        at_cycle(36);
        start = 1'b0;
        at_cycle(40);
        stop = 1'b1;
        at_cycle(41);
        stop = 1'b0;
        sample_at(49);
        chk("frm_after_f2", 64'(a_frm), 64'(FC * 2));
        sample_at(54);
        chk("busy_last_vblk", 64'(a_busy), 64'd1);
        sample_at(55);
        chk("busy_idle_f2", 64'(a_busy), 64'd0);

        // Stop during first line of a pattern-3 frame.
        pat = 2'd3;
        push_frame(61, 3, 8'h00, 4, 3, 6, 1000, 1'b0);
        at_cycle(60);
        start = 1'b1;
        at_cycle(61);
        start = 1'b0;
        at_cycle(65);
        stop = 1'b1;
        at_cycle(66);
        stop = 1'b0;
        sample_at(82);
        chk("stop_busy_vblk", 64'(a_busy), 64'd1);
        sample_at(83);
        chk("stop_busy_fall", 64'(a_busy), 64'd0);
        chk("frm_after_f3", 64'(a_frm), 64'(FC * 3));

        // Start and stop together: one solid frame, mid-frame select changes ignored.
        pat = 2'd2;
        solid = 8'hA5;
        push_frame(91, 2, 8'hA5, 4, 3, 6, 1000, 1'b0);
        at_cycle(90);
        start = 1'b1;
        stop = 1'b1;
        at_cycle(91);
        start = 1'b0;
        stop = 1'b0;
        at_cycle(95);
        pat = 2'd0;
        solid = 8'h3C;
        sample_at(112);
        chk("solo_busy_vblk", 64'(a_busy), 64'd1);
        sample_at(113);
        chk("solo_busy_fall", 64'(a_busy), 64'd0);

        // Reset mid-frame, then restart from line 0.
        push_frame(121, 0, 8'h00, 4, 3, 6, 127, 1'b0);
        at_cycle(120);
        start = 1'b1;
        at_cycle(121);
        start = 1'b0;
        at_cycle(128);
        rst = 1'b1;
        #1;
        chk("rst_mid_frame", {a_data, a_href, a_hstr, a_hend, a_vstr, a_vend,
            a_busy, a_frm}, 64'd0);
        at_cycle(130);
        rst = 1'b0;
        sample_at(134);
        chk("idle_after_rst2", 64'(a_busy), 64'd0);
        push_frame(136, 0, 8'h00, 4, 3, 6, 1000, 1'b0);
        at_cycle(135);
        start = 1'b1;
        at_cycle(136);
        start = 1'b0;
        at_cycle(140);
        stop = 1'b1;
        at_cycle(141);
        stop = 1'b0;
        sample_at(152);
        chk("frm_after_rst", 64'(a_frm), 64'(FC * 1));
        sample_at(157);
        chk("rst_busy_vblk", 64'(a_busy), 64'd1);
        sample_at(158);
        chk("rst_busy_fall", 64'(a_busy), 64'd0);

        // Checkerboard on a 16-pixel line.
        push_frame(171, 3, 8'h00, 16, 2, 17, 1000, 1'b1);
        at_cycle(170);
        b_start = 1'b1;
        b_stop = 1'b1;
        at_cycle(171);
        b_start = 1'b0;
        b_stop = 1'b0;
        sample_at(220);
        chk("b_busy_vblk", 64'(b_busy), 64'd1);
        sample_at(221);
        chk("b_busy_fall", 64'(b_busy), 64'd0);

        sample_at(226);
        chk("a_queue_drained", 64'(q1.size()), 64'd0);
        chk("b_queue_drained", 64'(q2.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vid_stream_gen.md
VID_STREAM_GEN -- requirements
Module: vid_stream_gen

Interface
REQ-001 Parameter DBUF_DW, default 8: pixel data width.
REQ-002 Parameter IMG_HSZ, default 1920: active pixels per line (>=2).
REQ-003 Parameter IMG_VSZ, default 1080: active lines per frame (>=2).
REQ-004 Parameter HBLK_SZ, default 280: horizontal blanking cycles after each active line (>=1).
REQ-005 Parameter VBLK_SZ, default 45: vertical blanking lines after each frame (>=1), each line IMG_HSZ+HBLK_SZ cycles.
REQ-006 Ports: clk in 1, sole clock; rst in 1, asynchronous active-high reset.
REQ-007 Ports: i_start in 1, start pulse; i_stop in 1, stop request pulse; i_pat_sel in 2, pattern select; i_solid in DBUF_DW, solid pattern value.
REQ-008 Ports: o_data out DBUF_DW; o_href out 1, pixel valid; o_hstr out 1, first pixel of line; o_hend out 1, last pixel of line; o_vstr out 1, first pixel of frame; o_vend out 1, last pixel of frame.
REQ-009 Ports: o_busy out 1, generator not idle; o_frm_cnt out 16, completed frame count.

Function
REQ-010 All outputs SHALL be registered; stream format SHALL match the line buffer input stream (i_data/i_href/i_hstr/i_hend/i_vstr).
REQ-011 FSM states SHALL be IDLE, ACT, HBLK, VBLK; horizontal counter hcnt and line counter vcnt drive transitions.
REQ-012 IDLE: i_start high at cycle N -> ACT, first o_href/o_hstr/o_vstr at cycle N+1; i_start in any other state SHALL be ignored.
REQ-013 ACT: o_href high exactly IMG_HSZ consecutive cycles, hcnt 0..IMG_HSZ-1; o_hstr at hcnt 0, o_hend at hcnt IMG_HSZ-1.
REQ-014 ACT -> HBLK after last pixel; HBLK lasts HBLK_SZ cycles with o_href low, then ACT for next line while vcnt < IMG_VSZ-1.
REQ-015 o_vstr SHALL coincide with o_hstr of line 0; o_vend SHALL coincide with o_hend of line IMG_VSZ-1; after that line the FSM goes directly to VBLK (no HBLK).
REQ-016 VBLK lasts VBLK_SZ*(IMG_HSZ+HBLK_SZ) cycles, all strobes low; then ACT (new frame) unless stop pending, else IDLE.
REQ-017 i_stop in any non-IDLE state SHALL set stop-pending; current frame completes including VBLK; pending cleared on entering IDLE.
REQ-018 i_start and i_stop in the same IDLE cycle SHALL produce exactly one frame then IDLE.
REQ-019 i_pat_sel and i_solid SHALL be latched in the cycle before each frame's first pixel and held constant for that frame.
REQ-020 Patterns: 0 = hcnt[DBUF_DW-1:0]; 1 = vcnt[DBUF_DW-1:0]; 2 = latched i_solid; 3 = all-ones if hcnt[3]^vcnt[3] else zero; counters wrap modulo 2^DBUF_DW.
REQ-021 o_data SHALL be 0 whenever o_href is low.
REQ-022 o_busy SHALL be high in every non-IDLE state, low in IDLE.
REQ-023 o_frm_cnt SHALL increment by 1 in the cycle after o_vend, wrapping 0xFFFF -> 0.

Reset
REQ-024 rst high SHALL immediately force IDLE, hcnt=vcnt=0, stop-pending=0, all outputs 0, o_frm_cnt 0, including mid-frame.
REQ-025 After rst deasserts the block SHALL remain IDLE until i_start.

Configuration
REQ-026 Macro VSG_FRM_CNT_EN defined: o_frm_cnt behaves per REQ-023.
REQ-027 Macro VSG_FRM_CNT_EN undefined: counter logic absent, o_frm_cnt tied to 0; all other behaviour unchanged.

Verification (IMG_HSZ=4, IMG_VSZ=3, HBLK_SZ=2, VBLK_SZ=1, DBUF_DW=8)
REQ-028 i_start at cycle 10, pat 0 -> o_href cycles 11-14, 17-20, 23-26; o_data 0,1,2,3 per line; o_vstr at 11, o_vend at 26.
REQ-029 Continuous run -> second frame o_vstr at cycle 33 (VBLK 27-32); o_frm_cnt 1 at cycle 27.
REQ-030 i_stop at cycle 15 -> frame completes, o_busy falls at cycle 33, no second o_vstr.
REQ-031 i_start+i_stop same cycle, pat 2, i_solid=0xA5 -> one frame of 0xA5, then IDLE; i_pat_sel change mid-frame has no effect.
REQ-032 rst asserted at cycle 18 -> all outputs 0 same cycle; new i_start after release restarts from line 0 with o_vstr.
REQ-033 Pattern 3 with IMG_HSZ=16 -> o_data 0x00 for hcnt 0-7, 0xFF for hcnt 8-15 on line 0.
